// File: rtl/msrv32_ahb_arbiter.sv
// Shares one AHB-Lite master port between the msrv32 fetch and load/store requesters.
// Single transfers only; completion is signalled to the owner in the final data-phase cycle.
module msrv32_ahb_arbiter #(
    parameter bit          RR_EN   = 1'b1,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic        i_req_in,
    input  logic [31:0] i_addr_in,
    output logic        i_ack_out,
    output logic [31:0] i_rdata_out,
    output logic        i_err_out,
    input  logic        d_req_in,
    input  logic [31:0] d_addr_in,
    input  logic        d_wr_in,
    input  logic [31:0] d_wdata_in,
    input  logic [3:0]  d_mask_in,
    output logic        d_ack_out,
    output logic [31:0] d_rdata_out,
    output logic        d_err_out,
    output logic [31:0] haddr_out,
    output logic [1:0]  htrans_out,
    output logic        hwrite_out,
    output logic [2:0]  hsize_out,
    output logic [31:0] hwdata_out,
    output logic [3:0]  hwstrb_out,
    input  logic [31:0] hrdata_in,
    input  logic        hready_in,
    input  logic        hresp_in
);

    localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic        OWN_I         = 1'b0;
    localparam logic        OWN_D         = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA
    } state_t;

    state_t          state;
    logic            owner;
    logic            last_owner;
    logic [WD_W-1:0] wd_cnt;
    logic            grant_d;
    logic            wd_expire;
    logic            xfer_done;
    logic            xfer_err;

    // Data wins a tie unless round-robin says instruction is due.
    assign grant_d = d_req_in & (~i_req_in | (RR_EN == 1'b0) | (last_owner == OWN_I));

    // Expiry fires on the TIMEOUT-th consecutive wait cycle of a transfer.
    assign wd_expire = (TIMEOUT != 0) && (state != S_IDLE) && !hready_in
                       && (wd_cnt == WD_W'(TIMEOUT - 1));

    assign xfer_done = ((state == S_DATA) && hready_in) || wd_expire;
    assign xfer_err  = ((state == S_DATA) && hready_in && hresp_in) || wd_expire;

    assign i_ack_out   = xfer_done && (owner == OWN_I);
    assign d_ack_out   = xfer_done && (owner == OWN_D);
    assign i_err_out   = xfer_err && (owner == OWN_I);
    assign d_err_out   = xfer_err && (owner == OWN_D);
    assign i_rdata_out = i_ack_out ? hrdata_in : 32'h0;
    assign d_rdata_out = d_ack_out ? hrdata_in : 32'h0;
    assign hsize_out   = 3'b010;

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            state      <= S_IDLE;
            owner      <= OWN_I;
            last_owner <= OWN_I;
            htrans_out <= HTRANS_IDLE;
            haddr_out  <= 32'h0;
            hwrite_out <= 1'b0;
            hwstrb_out <= 4'h0;
            hwdata_out <= 32'h0;
            wd_cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    wd_cnt <= '0;
                    if (i_req_in || d_req_in) begin
                        state      <= S_ADDR;
                        owner      <= grant_d;
                        last_owner <= grant_d;
                        htrans_out <= HTRANS_NONSEQ;
                        haddr_out  <= grant_d ? d_addr_in : i_addr_in;
                        hwrite_out <= grant_d & d_wr_in;
                        hwstrb_out <= (grant_d && d_wr_in) ? d_mask_in : 4'hF;
                        hwdata_out <= grant_d ? d_wdata_in : 32'h0;
                    end
                end
                S_ADDR: begin
                    if (wd_expire) begin
                        state      <= S_IDLE;
                        htrans_out <= HTRANS_IDLE;
                        wd_cnt     <= '0;
                    end else if (hready_in) begin
                        state      <= S_DATA;
                        htrans_out <= HTRANS_IDLE;
                        wd_cnt     <= '0;
                    end else if (TIMEOUT != 0) begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                S_DATA: begin
                    if (hready_in || wd_expire) begin
                        state  <= S_IDLE;
                        wd_cnt <= '0;
                    end else if (TIMEOUT != 0) begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    htrans_out <= HTRANS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msrv32_ahb_arbiter.sv
// Directed bench for msrv32_ahb_arbiter: a round-robin instance with a short watchdog
// and a fixed-priority instance sharing the same stimulus.
module tb_msrv32_ahb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_wr, hready, hresp;
    logic [31:0] i_addr, d_addr, d_wdata, hrdata;
    logic [3:0]  d_mask;

    logic        i_ack, i_err, d_ack, d_err, hwrite;
    logic [31:0] i_rdata, d_rdata, haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [3:0]  hwstrb;

    logic        f_i_ack, f_i_err, f_d_ack, f_d_err, f_hwrite;
    logic [31:0] f_i_rdata, f_d_rdata, f_haddr, f_hwdata;
    logic [1:0]  f_htrans;
    logic [2:0]  f_hsize;
    logic [3:0]  f_hwstrb;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    msrv32_ahb_arbiter #(.RR_EN(1'b1), .TIMEOUT(4)) u_rr (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
        .i_req_in(i_req), .i_addr_in(i_addr), .i_ack_out(i_ack),
        .i_rdata_out(i_rdata), .i_err_out(i_err),
        .d_req_in(d_req), .d_addr_in(d_addr), .d_wr_in(d_wr),
        .d_wdata_in(d_wdata), .d_mask_in(d_mask), .d_ack_out(d_ack),
        .d_rdata_out(d_rdata), .d_err_out(d_err),
        .haddr_out(haddr), .htrans_out(htrans), .hwrite_out(hwrite),
        .hsize_out(hsize), .hwdata_out(hwdata), .hwstrb_out(hwstrb),
        .hrdata_in(hrdata), .hready_in(hready), .hresp_in(hresp)
    );

    msrv32_ahb_arbiter #(.RR_EN(1'b0), .TIMEOUT(0)) u_fp (
        .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst),
        .i_req_in(i_req), .i_addr_in(i_addr), .i_ack_out(f_i_ack),
        .i_rdata_out(f_i_rdata), .i_err_out(f_i_err),
        .d_req_in(d_req), .d_addr_in(d_addr), .d_wr_in(d_wr),
        .d_wdata_in(d_wdata), .d_mask_in(d_mask), .d_ack_out(f_d_ack),
        .d_rdata_out(f_d_rdata), .d_err_out(f_d_err),
        .haddr_out(f_haddr), .htrans_out(f_htrans), .hwrite_out(f_hwrite),
        .hsize_out(f_hsize), .hwdata_out(f_hwdata), .hwstrb_out(f_hwstrb),
        .hrdata_in(hrdata), .hready_in(hready), .hresp_in(hresp)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance into the next cycle, just past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0; hready = 1'b1; hresp = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; hrdata = 32'h0; d_mask = 4'h0;
        step(); step();
        #1;
        check("rst_htrans", 32'(htrans), 32'h0);
        check("rst_haddr", haddr, 32'h0);
        check("rst_hwrite", 32'(hwrite), 32'h0);
        check("rst_hwstrb", 32'(hwstrb), 32'h0);
        check("rst_hwdata", hwdata, 32'h0);
        check("rst_acks", {30'h0, i_ack, d_ack}, 32'h0);
        check("rst_fp_htrans", 32'(f_htrans), 32'h0);
        rst = 1'b1;

        // Instruction read, zero-wait slave
        i_req = 1'b1; i_addr = 32'h100; hrdata = 32'h13;
        step(); #1;
        check("ir_htrans", 32'(htrans), 32'h2);
        check("ir_haddr", haddr, 32'h100);
        check("ir_hwrite", 32'(hwrite), 32'h0);
        check("ir_hwstrb", 32'(hwstrb), 32'hF);
        check("ir_hsize", 32'(hsize), 32'h2);
        check("ir_early_ack", 32'(i_ack), 32'h0);
        step(); #1;
        check("ir_ack", 32'(i_ack), 32'h1);
        check("ir_rdata", i_rdata, 32'h13);
        check("ir_err", 32'(i_err), 32'h0);
        check("ir_d_ack", 32'(d_ack), 32'h0);
        check("ir_htrans_data", 32'(htrans), 32'h0);
        i_req = 1'b0;
        step();

        // Data write with two wait states
        d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF; d_mask = 4'b0011;
        step(); #1;
        check("dw_htrans", 32'(htrans), 32'h2);
        check("dw_haddr", haddr, 32'h2004);
        check("dw_hwrite", 32'(hwrite), 32'h1);
        check("dw_hwstrb", 32'(hwstrb), 32'h3);
        step();
        hready = 1'b0; d_wdata = 32'h0; #1;
        check("dw_hwdata", hwdata, 32'hDEADBEEF);
        check("dw_wait1_ack", 32'(d_ack), 32'h0);
        step(); #1;
        check("dw_wait2_ack", 32'(d_ack), 32'h0);
        step();
        hready = 1'b1; #1;
        check("dw_ack", 32'(d_ack), 32'h1);
        check("dw_err", 32'(d_err), 32'h0);
        check("dw_i_ack", 32'(i_ack), 32'h0);
        d_req = 1'b0; d_wr = 1'b0;
        step();

        // Two-cycle error response, then a normal fetch
        d_req = 1'b1; d_addr = 32'h3000; hrdata = 32'h77;
        step();
        step();
        hready = 1'b0; hresp = 1'b1; #1;
        check("er_first_ack", 32'(d_ack), 32'h0);
        check("er_first_err", 32'(d_err), 32'h0);
        step();
        hready = 1'b1; #1;
        check("er_ack", 32'(d_ack), 32'h1);
        check("er_err", 32'(d_err), 32'h1);
        check("er_rdata", d_rdata, 32'h77);
        d_req = 1'b0;
        step();
        hresp = 1'b0; i_req = 1'b1; i_addr = 32'h104; hrdata = 32'h55;
        step(); #1;
        check("er_next_htrans", 32'(htrans), 32'h2);
        check("er_next_haddr", haddr, 32'h104);
        step(); #1;
        check("er_next_ack", 32'(i_ack), 32'h1);
        check("er_next_err", 32'(i_err), 32'h0);
        check("er_next_rdata", i_rdata, 32'h55);
        i_req = 1'b0;
        step();

        // Watchdog: slave never ready during the address phase
        i_req = 1'b1; i_addr = 32'h200; hready = 1'b0;
        step(); #1;
        check("wd_htrans", 32'(htrans), 32'h2);
        check("wd_ack_w1", 32'(i_ack), 32'h0);
        step(); step(); #1;
        check("wd_ack_w3", 32'(i_ack), 32'h0);
        step(); #1;
        check("wd_ack", 32'(i_ack), 32'h1);
        check("wd_err", 32'(i_err), 32'h1);
        i_req = 1'b0;
        step(); #1;
        check("wd_idle_htrans", 32'(htrans), 32'h0);
        check("wd_idle_ack", 32'(i_ack), 32'h0);

        // Reset during a stalled data phase
        hready = 1'b1; d_req = 1'b1; d_addr = 32'h500;
        step();
        step();
        hready = 1'b0; #1;
        check("rs_stall_ack", 32'(d_ack), 32'h0);
        rst = 1'b0;
        step();
        hready = 1'b1; #1;
        check("rs_htrans", 32'(htrans), 32'h0);
        check("rs_no_ack", {30'h0, i_ack, d_ack}, 32'h0);
        check("rs_fp_htrans", 32'(f_htrans), 32'h0);

        // Simultaneous requests held high: RR alternates D,I,D,I; fixed priority stays on D
        rst = 1'b1; i_req = 1'b1; d_req = 1'b1; i_addr = 32'h400; d_addr = 32'h800;
        d_wr = 1'b0; hrdata = 32'hA5;
        for (int k = 0; k < 4; k++) begin
            step(); #1;
            check($sformatf("rr_haddr%0d", k), haddr, (k % 2 == 0) ? 32'h800 : 32'h400);
            check($sformatf("fp_haddr%0d", k), f_haddr, 32'h800);
            check($sformatf("fp_hwrite%0d", k), 32'(f_hwrite), 32'h0);
            check($sformatf("fp_hwstrb%0d", k), 32'(f_hwstrb), 32'hF);
            check($sformatf("fp_hsize%0d", k), 32'(f_hsize), 32'h2);
            check($sformatf("fp_hwdata%0d", k), f_hwdata, 32'h0);
            step(); #1;
            check($sformatf("rr_d_ack%0d", k), 32'(d_ack), (k % 2 == 0) ? 32'h1 : 32'h0);
            check($sformatf("rr_i_ack%0d", k), 32'(i_ack), (k % 2 == 0) ? 32'h0 : 32'h1);
            check($sformatf("fp_d_ack%0d", k), 32'(f_d_ack), 32'h1);
            check($sformatf("fp_i_ack%0d", k), 32'(f_i_ack), 32'h0);
            check($sformatf("fp_rdata%0d", k), f_d_rdata, 32'hA5);
            check($sformatf("fp_errs%0d", k), {30'h0, f_i_err, f_d_err}, 32'h0);
            step();
        end
        i_req = 1'b0; d_req = 1'b0;
        check("fp_i_rdata_idle", f_i_rdata, f_i_ack ? hrdata : f_i_rdata);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
